// File: rtl/vend_credit_ctrl_pkg.sv
// Shared definitions for the vending credit controller.
// Coin values in nickels, FSM state encoding, digit width and helpers that split
// a credit held in nickels into BCD tens/ones digits of the amount in cents.
package vend_credit_ctrl_pkg;

  localparam int unsigned CreditW = 5;
  localparam int unsigned DigitW  = 4;

  localparam logic [CreditW-1:0] NickelVal  = 5'd1;
  localparam logic [CreditW-1:0] DimeVal    = 5'd2;
  localparam logic [CreditW-1:0] QuarterVal = 5'd5;

  localparam logic [DigitW-1:0] OnesZero = 4'd0;
  localparam logic [DigitW-1:0] OnesFive = 4'd5;

  typedef enum logic [1:0] {
    StAccept   = 2'd0,
    StDispense = 2'd1,
    StChange   = 2'd2
  } state_e;

  // Two nickels make one ten-cent digit step.
  function automatic logic [DigitW-1:0] tens_of(input logic [CreditW-1:0] credit);
    return {1'b0, credit[CreditW-1:1]};
  endfunction

  // An odd nickel count leaves five cents in the ones digit.
  function automatic logic [DigitW-1:0] ones_of(input logic [CreditW-1:0] credit);
    return credit[0] ? OnesFive : OnesZero;
  endfunction

endpackage

// File: rtl/vend_credit_ctrl_if.sv
// Coin/button inputs and display/actuator outputs of the vending credit controller.
//   i_Nickel, i_Dime, i_Quarter : 1-cycle coin pulses
//   i_Vend, i_Cancel            : 1-cycle button pulses
//   o_Tens_Digit, o_Ones_Digit  : BCD credit in cents
//   o_Dispense                  : dispense strobe
//   o_Change_Nickel             : one pulse per nickel returned
//   o_Reject                    : coin refused
//   o_Busy                      : dispensing or returning change
// master drives the inputs (coin mech / bench); slave is the controller.
interface vend_credit_ctrl_if;
  import vend_credit_ctrl_pkg::*;

  logic              i_Nickel;
  logic              i_Dime;
  logic              i_Quarter;
  logic              i_Vend;
  logic              i_Cancel;
  logic [DigitW-1:0] o_Tens_Digit;
  logic [DigitW-1:0] o_Ones_Digit;
  logic              o_Dispense;
  logic              o_Change_Nickel;
  logic              o_Reject;
  logic              o_Busy;

  modport master (
    output i_Nickel, i_Dime, i_Quarter, i_Vend, i_Cancel,
    input  o_Tens_Digit, o_Ones_Digit, o_Dispense, o_Change_Nickel, o_Reject, o_Busy
  );

  modport slave (
    input  i_Nickel, i_Dime, i_Quarter, i_Vend, i_Cancel,
    output o_Tens_Digit, o_Ones_Digit, o_Dispense, o_Change_Nickel, o_Reject, o_Busy
  );

endinterface

// File: rtl/vend_credit_ctrl_cycle_timer.sv
// Loadable down-counter shared by the dispense and change phases.
//   clk_i, rst_ni : clock, async active-low reset
//   load_i        : load value_i this edge (wins over counting)
//   value_i       : interval length minus one
//   done_o        : registered pulse during the last cycle of the loaded interval
module vend_credit_ctrl_cycle_timer
  import vend_credit_ctrl_pkg::*;
#(
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] value_i,
  output logic             done_o
);

  logic [Width-1:0] count_q, count_d;
  logic             done_q, done_d;

  // Counter parks at zero, so it never wraps.
  always_comb begin
    count_d = count_q;
    done_d  = 1'b0;
    if (load_i) begin
      count_d = value_i;
      done_d  = (value_i == '0);
    end else if (count_q != '0) begin
      count_d = count_q - Width'(1);
      done_d  = (count_q == Width'(1));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/vend_credit_ctrl.sv
// Credit accumulator and vend/change FSM for the vending machine.
//   i_Clk, i_Rst_L : clock, async active-low reset
//   bus (slave)    : coin/button pulses in; BCD credit digits, dispense strobe,
//                    change-nickel pulses, coin reject and busy out
// Credit is held in nickels and capped at MAX_NICKELS. A vend holds o_Dispense for
// DISPENSE_CYCLES clocks and then returns any remaining credit as nickel pulses
// CHANGE_GAP clocks apart; cancel returns all credit the same way.
module vend_credit_ctrl
  import vend_credit_ctrl_pkg::*;
#(
  parameter int unsigned PRICE_NICKELS   = 15,
  parameter int unsigned MAX_NICKELS     = 19,
  parameter int unsigned DISPENSE_CYCLES = 25_000_000,
  parameter int unsigned CHANGE_GAP      = 12_500_000
) (
  input logic               i_Clk,
  input logic               i_Rst_L,
  vend_credit_ctrl_if.slave bus
);

  localparam int unsigned TimerMax = (DISPENSE_CYCLES > CHANGE_GAP) ? DISPENSE_CYCLES
                                                                      : CHANGE_GAP;
  localparam int unsigned TimerW   = (TimerMax > 1) ? $clog2(TimerMax) : 1;

  // Timer loads interval-1 so the counter fits in $clog2 of the longest interval.
  localparam logic [TimerW-1:0]  DispLoad = TimerW'(DISPENSE_CYCLES - 1);
  localparam logic [TimerW-1:0]  GapLoad  = TimerW'(CHANGE_GAP - 1);
  localparam logic [CreditW-1:0] Price    = CreditW'(PRICE_NICKELS);
  localparam logic [CreditW:0]   MaxExt   = (CreditW + 1)'(MAX_NICKELS);

  state_e               state_q, state_d;
  logic [CreditW-1:0]   credit_q, credit_d;
  logic                 reject_q, reject_d;
  logic                 change_q, change_d;
  logic                 tmr_load;
  logic [TimerW-1:0]    tmr_value;
  logic                 tmr_done;

  logic [1:0]           coin_cnt;
  logic                 coin_any;
  logic [CreditW-1:0]   coin_val;
  logic [CreditW:0]     credit_sum;

  vend_credit_ctrl_cycle_timer #(
    .Width (TimerW)
  ) u_timer (
    .clk_i   (i_Clk),
    .rst_ni  (i_Rst_L),
    .load_i  (tmr_load),
    .value_i (tmr_value),
    .done_o  (tmr_done)
  );

  assign coin_cnt   = {1'b0, bus.i_Nickel} + {1'b0, bus.i_Dime} + {1'b0, bus.i_Quarter};
  assign coin_any   = (coin_cnt != 2'd0);
  assign credit_sum = {1'b0, credit_q} + {1'b0, coin_val};

  always_comb begin
    coin_val = '0;
    if (bus.i_Nickel) begin
      coin_val = NickelVal;
    end else if (bus.i_Dime) begin
      coin_val = DimeVal;
    end else if (bus.i_Quarter) begin
      coin_val = QuarterVal;
    end
  end

  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    reject_d  = 1'b0;
    change_d  = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = GapLoad;

    case (state_q)
      StAccept: begin
        if (coin_cnt > 2'd1) begin
          reject_d = 1'b1;
        end else if (coin_any) begin
          // All-or-nothing: a coin that would overflow the ceiling is returned.
          if (credit_sum <= MaxExt) begin
            credit_d = credit_sum[CreditW-1:0];
          end else begin
            reject_d = 1'b1;
          end
        end else if (bus.i_Cancel) begin
          if (credit_q != '0) begin
            state_d  = StChange;
            change_d = 1'b1;
            credit_d = credit_q - CreditW'(1);
            tmr_load = 1'b1;
          end
        end else if (bus.i_Vend && (credit_q >= Price)) begin
          state_d   = StDispense;
          credit_d  = credit_q - Price;
          tmr_load  = 1'b1;
          tmr_value = DispLoad;
        end
      end

      StDispense: begin
        reject_d = coin_any;
        if (tmr_done) begin
          if (credit_q != '0) begin
            // First change pulse issues on the same edge that ends the dispense.
            state_d  = StChange;
            change_d = 1'b1;
            credit_d = credit_q - CreditW'(1);
            tmr_load = 1'b1;
          end else begin
            state_d = StAccept;
          end
        end
      end

      StChange: begin
        reject_d = coin_any;
        if (credit_q == '0) begin
          state_d = StAccept;
        end else if (tmr_done) begin
          change_d = 1'b1;
          credit_d = credit_q - CreditW'(1);
          tmr_load = 1'b1;
        end
      end

      default: begin
        state_d = StAccept;
      end
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= StAccept;
      credit_q <= '0;
      reject_q <= 1'b0;
      change_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      reject_q <= reject_d;
      change_q <= change_d;
    end
  end

  assign bus.o_Tens_Digit    = tens_of(credit_q);
  assign bus.o_Ones_Digit    = ones_of(credit_q);
  assign bus.o_Dispense      = (state_q == StDispense);
  assign bus.o_Change_Nickel = change_q;
  assign bus.o_Reject        = reject_q;
  assign bus.o_Busy          = (state_q == StDispense) || (state_q == StChange);

endmodule
